fetch_ifid_stage: RTL and testbench
===================================

Name: fetch_ifid_stage

Overview:
- Instruction-fetch front end of the pipelined MIPS core.
- Owns the PC register and drives the Address input of the program memory ROM.
- Selects the next PC from sequential, branch, jump and jump-register sources.
- Captures the ROM's combinational Instruction output, with PC+4, into the IF/ID pipeline register, including stall and flush handling.

Parameters:
- DATA_WIDTH, 32: instruction and address width.
- PC_RESET, 32'h0000_0000: PC value loaded on reset. Must be word aligned.
- NOP_WORD, 32'h0000_0000: instruction inserted into IF/ID on flush (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard unit: hold PC and IF/ID.
- BranchTaken  in  1  ID-stage branch resolved taken.
- BranchTarget  in  32  branch target byte address.
- Jump  in  1  ID-stage j/jal.
- JumpIndex  in  26  instr_index field of the jump.
- JumpReg  in  1  ID-stage jr/jalr.
- JumpRegTarget  in  32  rs value for jr.
- Instruction  in  32  combinational ROM output for the current PC.
- PC  out  32  current fetch address, to ROM Address.
- IFID_Instruction  out  32  registered instruction to decode.
- IFID_PCPlus4  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  1 = IF/ID holds a real fetched instruction.
- MisalignFault  out  1  sticky: a redirect target had bits[1:0] != 0.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - PC=PC_RESET, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, MisalignFault=0.
  - Reset asserted mid-operation discards all in-flight state immediately.
- PC+4 is a 32-bit modulo add: 32'hFFFF_FFFC+4 = 0. No carry out and no fault.
- Jump target = {IFID_PCPlus4[31:28], JumpIndex, 2'b00}. It uses the ID-stage PC+4, not the fetch PC.
- Redirect request R = JumpReg | Jump | BranchTaken.
- Target priority when several are asserted: JumpReg > Jump > BranchTaken.
- Per rising clk edge, evaluated in this order:
  1. R=1 (overrides Stall):
     - PC <= selected target with bits[1:0] forced to 00.
     - IF/ID flushed: IFID_Instruction <= NOP_WORD, IFID_PCPlus4 <= 0, IFID_Valid <= 0.
     - If the unmasked target[1:0] != 0, MisalignFault <= 1.
  2. Else if Stall=1: PC, IFID_Instruction, IFID_PCPlus4 and IFID_Valid all hold.
  3. Else:
     - PC <= PC+4.
     - IFID_Instruction <= Instruction, IFID_PCPlus4 <= PC+4, IFID_Valid <= 1.
- MisalignFault clears only on reset.
- Latency:
  - PC reaches the ROM combinationally in the same cycle.
  - The instruction at PC appears on the IF/ID outputs after one clock edge.
  - A redirect costs one bubble; the target instruction reaches IF/ID on the second edge after the request.
- A Stall held for N cycles freezes the outputs for N edges; fetch resumes at the held PC with no skipped or duplicated instruction.
- Inputs are sampled only at the clock edge. Glitches between edges have no effect.
- No other internal state.
- Implementation: one PC always block and one IF/ID always block, both of the form always @(posedge clk or negedge reset); next-PC mux as combinational logic.

Test Plan:
- Reset then 4 free-running cycles, ROM words 0x20080005, 0x20090003, 0x01095020, 0x00000000 → PC = 0,4,8,12,16; IFID_Instruction follows one cycle behind; IFID_PCPlus4 = 4,8,12,16; IFID_Valid = 1 from the first edge.
- Stall=1 for 3 cycles at PC=8 → PC stays 8 and IF/ID stays {0x20090003, 8, 1}. After Stall drops, the next edge gives PC=12 and IFID_Instruction=0x01095020.
- BranchTaken=1, BranchTarget=0x40, Stall=1 simultaneously → PC=0x40, IFID_Instruction=0x0, IFID_Valid=0, MisalignFault=0. The next edge loads ROM[0x40>>2] with IFID_PCPlus4=0x44.
- Jump=1 and BranchTaken=1 together, JumpIndex=0x0000010, IFID_PCPlus4=0x10000008, BranchTarget=0x80 → PC=0x10000040 (jump wins).
- JumpReg=1, JumpRegTarget=0x0000_0022 → PC=0x20, MisalignFault=1, and it remains 1 through 10 further normal cycles.
- PC forced to 0xFFFFFFFC by a jr, then one free cycle → PC=0, IFID_PCPlus4=0. Then drop reset asynchronously mid-cycle (between clock edges) → all outputs take their reset values before the next clock edge.

Source files
------------

// File: rtl/fetch_ifid_if.sv
// Fetch-stage bus: hazard/decode control, ROM data and IF/ID outputs.
// The slave modport is the fetch stage itself; master is its surrounding core.
interface fetch_ifid_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Stall;
    logic                  BranchTaken;
    logic [DATA_WIDTH-1:0] BranchTarget;
    logic                  Jump;
    logic [25:0]           JumpIndex;
    logic                  JumpReg;
    logic [DATA_WIDTH-1:0] JumpRegTarget;
    logic [DATA_WIDTH-1:0] Instruction;
    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] IFID_Instruction;
    logic [DATA_WIDTH-1:0] IFID_PCPlus4;
    logic                  IFID_Valid;
    logic                  MisalignFault;

    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpIndex,
               JumpReg, JumpRegTarget, Instruction,
        input  PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, MisalignFault
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpIndex,
               JumpReg, JumpRegTarget, Instruction,
        output PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, MisalignFault
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// MIPS instruction-fetch front end: PC register, next-PC select and the
// IF/ID pipeline register with stall/flush handling.
module fetch_ifid_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ifid_if.slave   bus
);
    logic [DATA_WIDTH-1:0] pc_p0;
    logic                  misalign_p0;
    logic [DATA_WIDTH-1:0] ifid_instr_p1;
    logic [DATA_WIDTH-1:0] ifid_pcplus4_p1;
    logic                  vld_p1;

    logic                  redirect;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] jump_target;
    logic [DATA_WIDTH-1:0] pc_plus4;

    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
        return {a[DATA_WIDTH-1:2], 2'b00};
    endfunction

    assign pc_plus4    = pc_p0 + DATA_WIDTH'(4);
    // Region bits come from the decoding instruction's PC+4, not the fetch PC.
    assign jump_target = {ifid_pcplus4_p1[DATA_WIDTH-1 -: DATA_WIDTH-28], bus.JumpIndex, 2'b00};

    always_comb begin
        redirect = bus.JumpReg | bus.Jump | bus.BranchTaken;
        target   = bus.BranchTarget;
        if (bus.JumpReg) begin
            target = bus.JumpRegTarget;
        end else if (bus.Jump) begin
            target = jump_target;
        end
    end

    // ---- fetch stage (p0): PC and sticky misalignment flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_p0       <= PC_RESET;
            misalign_p0 <= 1'b0;
        end else if (redirect) begin
            pc_p0 <= word_align(target);
            if (target[1:0] != 2'b00) begin
                misalign_p0 <= 1'b1;
            end
        end else if (!bus.Stall) begin
            pc_p0 <= pc_plus4;
        end
    end

    // ---- IF/ID boundary (p1): a redirect flushes even while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_instr_p1   <= NOP_WORD;
            ifid_pcplus4_p1 <= '0;
            vld_p1          <= 1'b0;
        end else if (redirect) begin
            ifid_instr_p1   <= NOP_WORD;
            ifid_pcplus4_p1 <= '0;
            vld_p1          <= 1'b0;
        end else if (!bus.Stall) begin
            ifid_instr_p1   <= bus.Instruction;
            ifid_pcplus4_p1 <= pc_plus4;
            vld_p1          <= 1'b1;
        end
    end

    assign bus.PC               = pc_p0;
    assign bus.IFID_Instruction = ifid_instr_p1;
    assign bus.IFID_PCPlus4     = ifid_pcplus4_p1;
    assign bus.IFID_Valid       = vld_p1;
    assign bus.MisalignFault    = misalign_p0;
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage with a small combinational ROM model.
module tb_fetch_ifid_stage;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    fetch_ifid_if #(.DATA_WIDTH(32)) bus ();

    fetch_ifid_stage #(
        .DATA_WIDTH(32),
        .PC_RESET  (32'h0000_0000),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0003;
            32'h0000_0008: return 32'h0109_5020;
            32'h0000_000C: return 32'h0000_0000;
            32'h0000_0040: return 32'h1111_2222;
            32'h0000_0044: return 32'h3333_4444;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.Instruction = rom_word(bus.PC);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] p4, input logic vld);
        chk({tag, ".pc"},    bus.PC,               pc);
        chk({tag, ".instr"}, bus.IFID_Instruction, ins);
        chk({tag, ".pc4"},   bus.IFID_PCPlus4,     p4);
        chk({tag, ".vld"},   {31'd0, bus.IFID_Valid}, {31'd0, vld});
    endtask

    task automatic clear_ctrl();
        bus.Stall         = 1'b0;
        bus.BranchTaken   = 1'b0;
        bus.BranchTarget  = 32'h0;
        bus.Jump          = 1'b0;
        bus.JumpIndex     = 26'h0;
        bus.JumpReg       = 1'b0;
        bus.JumpRegTarget = 32'h0;
    endtask

    logic [31:0] exp_instr [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_instr[0] = 32'h2008_0005;
        exp_instr[1] = 32'h2009_0003;
        exp_instr[2] = 32'h0109_5020;
        exp_instr[3] = 32'h0000_0000;
        clear_ctrl();
        reset = 1'b0;

        #12;
        chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset.fault", {31'd0, bus.MisalignFault}, 32'd0);
        reset = 1'b1;

        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_ifid($sformatf("free%0d", k), 32'(4 * k), exp_instr[k-1], 32'(4 * k), 1'b1);
        end

        // Re-reset between edges, then advance to PC=8
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        tick();
        tick();
        chk_ifid("pre_stall", 32'h8, 32'h2009_0003, 32'h8, 1'b1);

        bus.Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_ifid($sformatf("stall%0d", k), 32'h8, 32'h2009_0003, 32'h8, 1'b1);
        end
        bus.Stall = 1'b0;
        tick();
        chk_ifid("unstall", 32'hC, 32'h0109_5020, 32'hC, 1'b1);

        // Branch overrides a simultaneous stall
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h40;
        bus.Stall        = 1'b1;
        tick();
        chk_ifid("br_stall", 32'h40, 32'h0, 32'h0, 1'b0);
        chk("br_stall.fault", {31'd0, bus.MisalignFault}, 32'd0);
        clear_ctrl();
        tick();
        chk_ifid("br_tgt", 32'h44, 32'h1111_2222, 32'h44, 1'b1);

        // Set up IFID_PCPlus4 = 0x10000008 via a jr
        bus.JumpReg       = 1'b1;
        bus.JumpRegTarget = 32'h1000_0004;
        tick();
        chk_ifid("jr_setup", 32'h1000_0004, 32'h0, 32'h0, 1'b0);
        clear_ctrl();
        tick();
        chk_ifid("jr_fetch", 32'h1000_0008, 32'hDEAD_BEEF, 32'h1000_0008, 1'b1);

        bus.Jump         = 1'b1;
        bus.JumpIndex    = 26'h000_0010;
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h80;
        tick();
        chk_ifid("jump_wins", 32'h1000_0040, 32'h0, 32'h0, 1'b0);
        chk("jump_wins.fault", {31'd0, bus.MisalignFault}, 32'd0);
        clear_ctrl();

        bus.JumpReg       = 1'b1;
        bus.JumpRegTarget = 32'h0000_0022;
        tick();
        chk("misalign.pc", bus.PC, 32'h20);
        chk("misalign.fault", {31'd0, bus.MisalignFault}, 32'd1);
        clear_ctrl();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("sticky%0d", k), {31'd0, bus.MisalignFault}, 32'd1);
        end
        chk("sticky.pc", bus.PC, 32'h48);

        // PC wrap at the top of the address space
        bus.JumpReg       = 1'b1;
        bus.JumpRegTarget = 32'hFFFF_FFFC;
        tick();
        chk("wrap_setup.pc", bus.PC, 32'hFFFF_FFFC);
        clear_ctrl();
        tick();
        chk_ifid("wrap", 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1);
        chk("wrap.fault", {31'd0, bus.MisalignFault}, 32'd1);
        tick();
        chk_ifid("post_wrap", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

        // Asynchronous reset mid-cycle
        #3 reset = 1'b0;
        #1;
        chk_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("async_rst.fault", {31'd0, bus.MisalignFault}, 32'd0);
        tick();
        chk_ifid("rst_held", 32'h0, 32'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
